// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: handshake bundle between the result paths (ALU, register
// file), the UART TX datapath and the uart_tx_sched scheduler.
// master: environment side (requesters and transmitter).
// slave : scheduler side.
interface uart_tx_sched_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ALU_W  = 16
);
    logic              alu_req;
    logic [ALU_W-1:0]  alu_data;
    logic              alu_ack;
    logic              rf_req;
    logic [DATA_W-1:0] rf_data;
    logic              rf_ack;
    logic              tx_busy;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              sched_busy;
    logic              tx_err;

    modport master (
        output alu_req, alu_data, rf_req, rf_data, tx_busy,
        input  alu_ack, rf_ack, tx_data, tx_valid, sched_busy, tx_err
    );

    modport slave (
        input  alu_req, alu_data, rf_req, rf_data, tx_busy,
        output alu_ack, rf_ack, tx_data, tx_valid, sched_busy, tx_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter between
// the ALU (ALU_W-bit words, sent low byte first) and the register file
// (DATA_W-bit values). One byte is issued per one-cycle tx_valid, paced by
// the rise and fall of tx_busy.
// Optional feature macro: UART_SCHED_WDOG_EN -- aborts a job when tx_busy
// fails to rise within RETRY_CYC cycles of tx_valid (pulses tx_err).
module uart_tx_sched #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ALU_W     = 16,
    parameter int unsigned RETRY_CYC = 4
) (
    input logic            clk,
    input logic            rest,
    uart_tx_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
    typedef enum logic {GRANT_RF, GRANT_ALU} grant_t;

    if (ALU_W != 2 * DATA_W || RETRY_CYC < 2) begin : g_cfg_check
        $error("uart_tx_sched: ALU_W must be 2*DATA_W and RETRY_CYC >= 2");
    end

    state_t            state_q, state_d;
    grant_t            last_q, last_d;
    logic [ALU_W-1:0]  shreg_q, shreg_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              alu_ack_q, alu_ack_d;
    logic              rf_ack_q, rf_ack_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              sched_busy_q, sched_busy_d;
    logic              tx_err_q, tx_err_d;
    logic              take_alu;

`ifdef UART_SCHED_WDOG_EN
    localparam int unsigned WD_W = $clog2(RETRY_CYC) + 1;
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        alu_ack_d  = 1'b0;
        rf_ack_d   = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_err_d   = 1'b0;
        take_alu   = 1'b0;
`ifdef UART_SCHED_WDOG_EN
        wd_d       = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.tx_busy && (bus.alu_req || bus.rf_req)) begin
                    // on a collision the requester not served last wins
                    if (bus.alu_req && bus.rf_req)
                        take_alu = (last_q == GRANT_RF);
                    else
                        take_alu = bus.alu_req;
                    if (take_alu) begin
                        shreg_d   = bus.alu_data;
                        cnt_d     = 2'd2;
                        alu_ack_d = 1'b1;
                        last_d    = GRANT_ALU;
                    end else begin
                        shreg_d   = {{(ALU_W-DATA_W){1'b0}}, bus.rf_data};
                        cnt_d     = 2'd1;
                        rf_ack_d  = 1'b1;
                        last_d    = GRANT_RF;
                    end
                    tx_valid_d = 1'b1;
                    tx_data_d  = shreg_d[DATA_W-1:0];
                    state_d    = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_HI;
`ifdef UART_SCHED_WDOG_EN
                wd_d    = '0;
`endif
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end
`ifdef UART_SCHED_WDOG_EN
                // tx_valid was one cycle before entry, so the limit is hit
                // on the (RETRY_CYC-1)th evaluation here
                else if (wd_q == WD_W'(RETRY_CYC - 2)) begin
                    tx_err_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    shreg_d = shreg_q >> DATA_W;
                    cnt_d   = cnt_q - 2'd1;
                    if (cnt_d != 2'd0) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = shreg_d[DATA_W-1:0];
                        state_d    = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        sched_busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q      <= IDLE;
            last_q       <= GRANT_RF;
            shreg_q      <= '0;
            cnt_q        <= '0;
            alu_ack_q    <= 1'b0;
            rf_ack_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            sched_busy_q <= 1'b0;
            tx_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            alu_ack_q    <= alu_ack_d;
            rf_ack_q     <= rf_ack_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            sched_busy_q <= sched_busy_d;
            tx_err_q     <= tx_err_d;
        end
    end

`ifdef UART_SCHED_WDOG_EN
    // Watchdog cycle counter for WAIT_HI
    always_ff @(posedge clk) begin
        if (rest) wd_q <= '0;
        else      wd_q <= wd_d;
    end
`endif

    assign bus.alu_ack    = alu_ack_q;
    assign bus.rf_ack     = rf_ack_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.sched_busy = sched_busy_q;
    assign bus.tx_err     = tx_err_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Scheduler that shares the single UART transmitter between two requesters: the ALU, which sends a 16-bit result, and the register file, which sends an 8-bit read value. It arbitrates round-robin and splits each ALU word into two byte frames, low byte first. It issues one byte at a time to the UART TX FSM and pairs each one-cycle `tx_valid` with the transmitter's `busy` rise and fall. It sits between the system controller's result paths and the UART TX datapath.

## Interface
- `DATA_W`, default 8: UART frame width.
- `ALU_W`, default 16: ALU result width; must equal 2*`DATA_W`.
- `RETRY_CYC`, default 4: watchdog limit in cycles (used only with `UART_SCHED_WDOG_EN`).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rest`  in  1  reset, synchronous, active-high.
- `alu_req`  in  1  ALU job request (level).
- `alu_data`  in  ALU_W  ALU result, valid while `alu_req`=1.
- `alu_ack`  out  1  one-cycle pulse: ALU job accepted, data captured.
- `rf_req`  in  1  register-file job request (level).
- `rf_data`  in  DATA_W  read data, valid while `rf_req`=1.
- `rf_ack`  out  1  one-cycle pulse: RF job accepted.
- `tx_busy`  in  1  busy from UART TX FSM.
- `tx_data`  out  DATA_W  byte to transmit; held stable from `tx_valid` until `tx_busy` falls.
- `tx_valid`  out  1  one-cycle data-valid pulse to the UART TX.
- `sched_busy`  out  1  high whenever state ≠ IDLE.
- `tx_err`  out  1  one-cycle watchdog abort pulse; tied 0 without `UART_SCHED_WDOG_EN`.

## Operation
- All outputs are registered. Reset values: `alu_ack`=0, `rf_ack`=0, `tx_valid`=0, `tx_data`=0, `sched_busy`=0, `tx_err`=0, state=IDLE, `last_grant`=RF, byte count=0.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
- **IDLE**: requests are sampled only here, and only when `tx_busy`=0.
  - With exactly one request pending, that requester is granted.
  - With both pending, the requester that is not `last_grant` is granted. After reset the ALU therefore wins the first collision.
  - On grant: the job data is captured into a ALU_W shift register (RF data is zero-extended). The byte count is set to 2 (ALU) or 1 (RF), the matching ack pulses, `last_grant` is updated, and the FSM goes to SEND.
- **SEND**: lasts one cycle with `tx_valid`=1 and `tx_data` = low byte of the shift register. Next state is WAIT_HI.
- **WAIT_HI**: waits for `tx_busy`=1, then goes to WAIT_LO.
- **WAIT_LO**: waits for `tx_busy`=0.
  - The shift register shifts right by `DATA_W` and the count decrements.
  - If the count is still nonzero, the FSM goes to SEND (high byte). Otherwise it goes to IDLE.
- Requesters hold `req`/`data` until they see ack, and must drop `req` in the ack cycle. A `req` still high when the FSM returns to IDLE is treated as a new job.
- Request changes outside IDLE are ignored.
- A `rest` assertion in any state returns everything to reset values on the next edge. No further bytes are issued. A frame already inside the UART TX completes on its own.

## Timing
- Request sampled high at edge E → at edge E+1, ack=1 and `tx_valid`=1 (both for one cycle) with `tx_data`=byte0.
- The UART TX raises busy one cycle after `tx_valid`, so WAIT_HI normally lasts one cycle.
- Gap between bytes of one ALU job: `tx_busy` seen low at edge F → `tx_valid` for byte1 at edge F+1.
- Back-to-back jobs: the earliest next grant is the edge after the FSM returns to IDLE, i.e. one idle cycle between jobs.
- `sched_busy` rises with ack and falls on the edge that re-enters IDLE.

## Configuration
- `UART_SCHED_WDOG_EN`
  - **Defined**: a counter runs in WAIT_HI. If `tx_busy` has not risen `RETRY_CYC` cycles after `tx_valid`, the job is aborted: `tx_err` pulses for one cycle, `tx_valid` stays 0, remaining bytes are discarded, and the FSM goes to IDLE. `last_grant` keeps the aborted requester.
  - **Undefined**: WAIT_HI waits indefinitely, no counter is instantiated, and `tx_err`=0.

## Test plan
- **Reset**: assert `rest` for 2 cycles → all outputs 0, `sched_busy`=0.
- **RF job**: `rf_req`=1, `rf_data`=0xA5, busy model raises one cycle after valid and holds 10 cycles → `rf_ack` and `tx_valid` together one edge later, `tx_data`=0xA5, single frame, return to IDLE.
- **ALU job**: `alu_data`=0x1234 → two `tx_valid` pulses carrying 0x34 then 0x12, the second exactly one cycle after busy falls. One `alu_ack` only.
- **Collision**: both requests high after reset → ALU served first (0xBEEF as 0xEF, 0xBE), then RF (0x5A). Then both high again → ALU, since RF was last.
- **Reset mid-job**: `rest` in WAIT_LO between the two ALU bytes → no second `tx_valid`, state IDLE, `tx_data`=0.
- **Watchdog** (with `UART_SCHED_WDOG_EN`, `RETRY_CYC`=4): hold `tx_busy`=0 after `tx_valid` → `tx_err` pulse 4 cycles after `tx_valid`, then IDLE. Without the macro, the FSM stays in WAIT_HI.
